// File: rtl/alu_pipe.sv
// Two-stage pipelined scaling ALU: stage 1 captures operands, stage 2 computes and registers
// the result with zero/negative flags and a one-cycle valid strobe.
module alu_pipe #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ROUND      = 1'b0,
  parameter bit          CLEAR_IDLE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     aluop_st,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [2:0]        sel,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     zero,
  output logic                     neg
);

  localparam int unsigned IW = 2 * DATA_W;

  logic                     v1;
  logic signed [DATA_W-1:0] a1;
  logic signed [DATA_W-1:0] b1;
  logic        [2:0]        sel1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      sel1 <= '0;
    end else begin
      v1 <= aluop_st;
      if (aluop_st) begin
        a1   <= a;
        b1   <= b;
        sel1 <= sel;
      end
    end
  end

  logic signed [IW-1:0]     ax;
  logic signed [IW-1:0]     bx;
  logic signed [IW-1:0]     s;
  logic signed [IW-1:0]     t;
  logic signed [IW-1:0]     bias;
  logic signed [IW-1:0]     sum;
  logic                     scaled;
  logic                     shift3;
  logic signed [DATA_W-1:0] res;

  always_comb begin
    ax     = {{DATA_W{a1[DATA_W-1]}}, a1};
    bx     = {{DATA_W{b1[DATA_W-1]}}, b1};
    s      = ax + bx;
    t      = '0;
    scaled = 1'b1;
    shift3 = 1'b0;
    unique case (sel1)
      3'b000: t = s;
      3'b001: t = ax - bx;
      3'b010: begin t = ax & bx; scaled = 1'b0; end
      3'b011: begin t = ax | bx; scaled = 1'b0; end
      3'b100: begin t = ax ^ bx; scaled = 1'b0; end
      3'b101: begin t = (ax >>> 1) + (bx <<< 2); shift3 = 1'b1; end
      3'b110: begin t = s + (s <<< 1); shift3 = 1'b1; end
      3'b111: begin t = (ax <<< 2) + (ax <<< 1) + (bx >>> 2); shift3 = 1'b1; end
    endcase
    // Half-LSB of the shifted result, i.e. 2^(k-1).
    bias = '0;
    if (ROUND) begin
      bias = shift3 ? IW'(4) : IW'(1);
    end
    sum = t + bias;
    if (!scaled) begin
      res = DATA_W'(t);
    end else if (shift3) begin
      res = DATA_W'(sum >>> 3);
    end else begin
      res = DATA_W'(sum >>> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (v1) begin
      out       <= res;
      out_valid <= 1'b1;
      zero      <= (res == '0);
      neg       <= res[DATA_W-1];
    end else begin
      out_valid <= 1'b0;
      if (CLEAR_IDLE) begin
        out  <= '0;
        zero <= 1'b0;
        neg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: two instances (truncate/hold and round/clear) share stimulus.
module tb_alu_pipe;

  localparam int W = 8;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b0;
  logic                aluop_st = 1'b0;
  logic signed [W-1:0] a        = '0;
  logic signed [W-1:0] b        = '0;
  logic        [2:0]   sel      = '0;

  logic signed [W-1:0] out0, out1;
  logic                val0, val1, z0, z1, n0, n1;

  alu_pipe #(.DATA_W(W), .ROUND(1'b0), .CLEAR_IDLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .aluop_st(aluop_st), .a(a), .b(b), .sel(sel),
    .out(out0), .out_valid(val0), .zero(z0), .neg(n0)
  );

  alu_pipe #(.DATA_W(W), .ROUND(1'b1), .CLEAR_IDLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .aluop_st(aluop_st), .a(a), .b(b), .sel(sel),
    .out(out1), .out_valid(val1), .zero(z1), .neg(n1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  typedef struct {
    logic signed [W-1:0] v;
    int                  ec;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  logic signed [W-1:0] hold_out = '0;
  logic                hold_z   = 1'b0;
  logic                hold_n   = 1'b0;

  function automatic int floordiv(int t, int d);
    int q = t / d;
    if ((t % d != 0) && (t < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: result = floor((t + R) / 2^k), low W bits.
  function automatic logic signed [W-1:0] model(int av, int bv, logic [2:0] s, bit rnd);
    int t;
    int k;
    k = 0;
    t = 0;
    case (s)
      3'd0: begin t = av + bv; k = 1; end
      3'd1: begin t = av - bv; k = 1; end
      3'd2: return W'(av & bv);
      3'd3: return W'(av | bv);
      3'd4: return W'(av ^ bv);
      3'd5: begin t = floordiv(av, 2) + 4 * bv; k = 3; end
      3'd6: begin t = 3 * (av + bv); k = 3; end
      default: begin t = 6 * av + floordiv(bv, 4); k = 3; end
    endcase
    return W'(floordiv(t + (rnd ? (1 << (k - 1)) : 0), 1 << k));
  endfunction

  task automatic check(string nm, logic signed [31:0] got, logic signed [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, expv);
    end
  endtask

  task automatic report(string nm);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpeek(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic monitor(int i, logic signed [W-1:0] o, logic v, logic z, logic n);
    exp_t e;
    if (rst_seen) begin
      check($sformatf("rst_valid%0d", i), 32'(v), 0);
      check($sformatf("rst_out%0d", i), o, 0);
      check($sformatf("rst_zero%0d", i), 32'(z), 0);
      check($sformatf("rst_neg%0d", i), 32'(n), 0);
      if (i == 0) begin
        hold_out = '0;
        hold_z   = 1'b0;
        hold_n   = 1'b0;
      end
      return;
    end
    while (qsize(i) > 0 && qpeek(i).ec < cyc) begin
      e = qpop(i);
      report($sformatf("missing_valid%0d (due cycle %0d)", i, e.ec));
    end
    if (v) begin
      if (qsize(i) > 0 && qpeek(i).ec == cyc) begin
        e = qpop(i);
        check($sformatf("out%0d", i), o, e.v);
        check($sformatf("zero%0d", i), 32'(z), 32'(e.v == 0));
        check($sformatf("neg%0d", i), 32'(n), 32'(e.v < 0));
        if (i == 0) begin
          hold_out = e.v;
          hold_z   = (e.v == 0);
          hold_n   = (e.v < 0);
        end
      end else begin
        report($sformatf("unexpected_valid%0d out=%0d", i, o));
      end
    end else begin
      if (qsize(i) > 0 && qpeek(i).ec == cyc) begin
        e = qpop(i);
        report($sformatf("missing_valid%0d (due cycle %0d)", i, e.ec));
      end
      if (i == 0) begin
        check("idle_hold_out0", o, hold_out);
        check("idle_hold_zero0", 32'(z), 32'(hold_z));
        check("idle_hold_neg0", 32'(n), 32'(hold_n));
      end else begin
        check("idle_clear_out1", o, 0);
        check("idle_clear_zero1", 32'(z), 0);
        check("idle_clear_neg1", 32'(n), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, out0, val0, z0, n0);
    monitor(1, out1, val1, z1, n1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    tick();
    aluop_st = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sel      = 3'($urandom);
  endtask

  // Drive one strobe; expected values come from the table when given, else from the model.
  task automatic issue(int av, int bv, logic [2:0] s, bit tbl, int e0, int e1);
    exp_t x;
    tick();
    aluop_st = 1'b1;
    a        = W'(av);
    b        = W'(bv);
    sel      = s;
    x.ec = cyc + 2;
    x.v  = tbl ? W'(e0) : model(int'(a), int'(b), s, 1'b0);
    q0.push_back(x);
    x.v  = tbl ? W'(e1) : model(int'(a), int'(b), s, 1'b1);
    q1.push_back(x);
  endtask

  task automatic issue_rand();
    logic signed [W-1:0] ra;
    logic signed [W-1:0] rb;
    ra = W'($urandom);
    rb = W'($urandom);
    issue(int'(ra), int'(rb), 3'($urandom), 1'b0, 0, 0);
  endtask

  // Directed vectors: a, b, sel, expected truncate, expected round.
  int da[10]  = '{100, -128,  127, -128,   0,  3, -3, 'h5A, 'h5A, 'h5A};
  int db[10]  = '{ 60,  127,  127, -128, 127,  0,  0, -91,  -91,  -91};
  int ds[10]  = '{  0,    1,    6,    7,   5,  0,  0,   2,    3,    4};
  int de0[10] = '{ 80, -128,   95, -100,  63,  1, -2,   0,   -1,   -1};
  int de1[10] = '{ 80, -127,   95, -100,  64,  2, -1,   0,   -1,   -1};

  initial begin
    rst_n    = 1'b0;
    aluop_st = 1'b1;
    a        = 8'sd17;
    b        = 8'sd5;
    repeat (2) tick();
    rst_n    = 1'b1;
    aluop_st = 1'b0;

    foreach (da[i]) issue(da[i], db[i], 3'(ds[i]), 1'b1, de0[i], de1[i]);
    repeat (3) drive_idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 6) issue_rand();
      else drive_idle();
    end

    // Reset one cycle after a strobe: the in-flight op must be discarded.
    issue_rand();
    issue_rand();
    tick();
    rst_n    = 1'b0;
    aluop_st = 1'b1;
    while (q0.size() > 0 && q0[$].ec > cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].ec > cyc) void'(q1.pop_back());
    tick();
    rst_n    = 1'b1;
    aluop_st = 1'b0;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) < 7) issue_rand();
      else drive_idle();
    end
    repeat (5) drive_idle();

    check("leftover_q0", q0.size(), 0);
    check("leftover_q1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's 8-bit scaling ALU. It accepts one operation per clock and returns DATA_W-bit signed results with a fixed two-cycle latency and a valid strobe. It adds optional round-to-nearest scaling, zero/negative flags, and a selectable idle-output policy. The block sits between the SPI receive register file, which supplies operands and opcodes, and the SPI transmit path, which consumes `out` on `out_valid`.

## Interface
- DATA_W, 8, operand and result width in bits (≥4)
- ROUND, 0, scaling mode for ops 000/001/101/110/111. 0 = truncate (floor); 1 = add half-LSB before the shift.
- CLEAR_IDLE, 0, idle-output policy. 0 = `out` holds the last result; 1 = `out` is driven to 0 in any cycle where `out_valid` is 0.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- aluop_st  in  1  operation strobe; operands and sel are captured when it is high
- a  in  DATA_W  signed operand A
- b  in  DATA_W  signed operand B
- sel  in  3  opcode
- out  out  DATA_W  signed result
- out_valid  out  1  one-cycle pulse per completed operation
- zero  out  1  out == 0, qualified by out_valid
- neg  out  1  out[DATA_W-1], qualified by out_valid

## Operation
- Stage 1 registers a, b, sel and aluop_st; these are v1, a1, b1, sel1. Stage 2 computes the result and registers out, out_valid, zero and neg.
- Internal arithmetic uses IW = 2·DATA_W signed, with a1 and b1 sign-extended. All right shifts are arithmetic.
- Scaled result r = (t + R) >>> k, where R = 2^(k-1) if ROUND=1 and 0 otherwise.
- out = r[DATA_W-1:0]. The opcode set below keeps r within DATA_W range, so no saturation logic exists.
- Opcodes:
  - 000: t = a+b, k=1
  - 001: t = a−b, k=1
  - 010: a&b, no scaling
  - 011: a|b, no scaling
  - 100: a^b, no scaling
  - 101: t = (a>>>1) + 4b, k=3
  - 110: t = 3(a+b), k=3
  - 111: t = 6a + (b>>>2), k=3
- ROUND has no effect on 010/011/100.
- zero and neg are computed from the stage-2 result. They update only on cycles where out_valid is asserted, and otherwise follow the out policy.
- No state machine. Throughput is one op per clock, with no back-pressure and no stalls.

## Timing
- Reset: sampled at a rising edge with rst_n = 0. out = 0, out_valid = 0, zero = 0, neg = 0, and stage-1 valid = 0. Both stages flush, so in-flight ops are discarded.
- An op captured at edge N (aluop_st = 1) produces out and out_valid = 1 in the cycle after edge N+2. Latency is 2.
- Back-to-back strobes yield consecutive out_valid pulses in the same order.
- Idle cycles (out_valid = 0):
  - CLEAR_IDLE = 0: out, zero and neg hold their last values.
  - CLEAR_IDLE = 1: out, zero and neg are 0.
- sel, a and b are don't-care when aluop_st = 0.
- If rst_n is deasserted at edge M, the earliest out_valid is after edge M+3 (strobe at M+1).
- aluop_st held high in the same cycle as rst_n = 0 is ignored.

## Test plan
- **Reset, then pipeline.** DATA_W=8, ROUND=0. Apply rst_n=0 for 2 cycles, then a=100, b=60, sel=000 at edge N. Required: all outputs 0 during reset; out_valid=1 with out=80 after edge N+2.
- **Sub and constant ops.**
  - sel=001, a=−128, b=127 → out=−128, neg=1.
  - sel=110, a=b=127 → out=95.
  - sel=111, a=b=−128 → out=−100.
  - sel=101, a=0, b=127 → out=63.
- **Rounding.** sel=000, b=0:
  - a=3 → out=1 with ROUND=0, out=2 with ROUND=1.
  - a=−3 → out=−2 with ROUND=0, out=−1 with ROUND=1.
- **Bitwise and zero flag.** a=0x5A, b=0xA5: sel=010 → out=0, zero=1; sel=011 → out=0xFF (−1), neg=1; sel=100 → out=0xFF.
- **Throughput and idle policy.** Apply 4 consecutive strobes, then idle. Required: 4 consecutive out_valid pulses with in-order results. After the pulses, CLEAR_IDLE=0 holds the last out; CLEAR_IDLE=1 drives out=0.
- **Reset mid-flight.** Strobe at edge N, rst_n=0 at edge N+1. Required: no out_valid at edge N+2, and out=0.
